// File: rtl/uart_packet_parser.sv
// Packet framing stage behind the UART receiver: PREFIX, address, length, payload, CRC.
// Routes payload bytes to one of N_SRC channels and flags bad address, bad CRC and stalls.
module uart_packet_parser #(
  parameter int unsigned N_SRC          = 8,
  parameter logic [7:0]  ADDR_BASE      = 8'h10,
  parameter logic [7:0]  PREFIX         = 8'hDD,
  parameter bit          CHECK_CRC      = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [7:0]       master_data,
  output logic [N_SRC-1:0] valid_bus,
  output logic             pkt_done,
  output logic             crc_err,
  output logic             addr_err,
  output logic             timeout_err,
  output logic             busy
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_DATA, S_CRC} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       chan_q, chan_d;
  logic             drop_q, drop_d;
  logic [7:0]       rem_q, rem_d;
  logic [7:0]       crc_q, crc_d;
  logic [7:0]       master_data_q, master_data_d;
  logic [N_SRC-1:0] valid_bus_q, valid_bus_d;
  logic             pkt_done_q, pkt_done_d;
  logic             crc_err_q, crc_err_d;
  logic             addr_err_q, addr_err_d;
  logic             timeout_err_q, timeout_err_d;
  logic             busy_q, busy_d;
  logic [7:0]       addr_off;

  always_comb begin
    state_d       = state_q;
    chan_d        = chan_q;
    drop_d        = drop_q;
    rem_d         = rem_q;
    crc_d         = crc_q;
    master_data_d = master_data_q;
    valid_bus_d   = '0;
    pkt_done_d    = 1'b0;
    crc_err_d     = 1'b0;
    addr_err_d    = 1'b0;
    timeout_err_d = 1'b0;
    addr_off      = rx_data - ADDR_BASE;

    if (state_q == S_IDLE || rx_valid) begin
      cnt_d = '0;
    end else begin
      cnt_d = (cnt_q == TMAX) ? TMAX : cnt_q + 1'b1;
    end

    if (rx_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_data == PREFIX) begin
            state_d = S_ADDR;
            crc_d   = '0;
          end
        end
        S_ADDR: begin
          chan_d     = addr_off;
          drop_d     = (32'(addr_off) >= N_SRC);
          addr_err_d = (32'(addr_off) >= N_SRC);
          crc_d      = rx_data;
          state_d    = S_LEN;
        end
        S_LEN: begin
          rem_d   = rx_data;
          crc_d   = crc_q ^ rx_data;
          state_d = (rx_data == 8'd0) ? S_CRC : S_DATA;
        end
        S_DATA: begin
          if (!drop_q) begin
            master_data_d = rx_data;
            for (int unsigned i = 0; i < N_SRC; i++) begin
              valid_bus_d[i] = (32'(chan_q) == i);
            end
          end
          crc_d = crc_q ^ rx_data;
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = S_CRC;
        end
        S_CRC: begin
          pkt_done_d = 1'b1;
          crc_err_d  = CHECK_CRC && (rx_data != crc_q);
          state_d    = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && cnt_d == TMAX) begin
      // expiry only without a byte this cycle; an arriving byte wins and restarts the count
      state_d       = S_IDLE;
      timeout_err_d = 1'b1;
      cnt_d         = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      chan_q        <= '0;
      drop_q        <= 1'b0;
      rem_q         <= '0;
      crc_q         <= '0;
      master_data_q <= '0;
      valid_bus_q   <= '0;
      pkt_done_q    <= 1'b0;
      crc_err_q     <= 1'b0;
      addr_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      chan_q        <= chan_d;
      drop_q        <= drop_d;
      rem_q         <= rem_d;
      crc_q         <= crc_d;
      master_data_q <= master_data_d;
      valid_bus_q   <= valid_bus_d;
      pkt_done_q    <= pkt_done_d;
      crc_err_q     <= crc_err_d;
      addr_err_q    <= addr_err_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
    end
  end

  assign master_data = master_data_q;
  assign valid_bus   = valid_bus_q;
  assign pkt_done    = pkt_done_q;
  assign crc_err     = crc_err_q;
  assign addr_err    = addr_err_q;
  assign timeout_err = timeout_err_q;
  assign busy        = busy_q;

endmodule
